serial_frame_rx: RTL and testbench
==================================

Name: serial_frame_rx

Overview:
- Parametrised bit-per-clock serial frame receiver; next-generation of the team's fixed 8N1 serial-data FSM.
- Adds configurable data width, optional even/odd parity, 1 or 2 stop bits, distinct parity and framing error pulses, and a saturating error counter.
- Sits behind a synchroniser on a serial input line and feeds word-wide consumers.
- One line bit is sampled per clk; there is no oversampling.

Parameters:
- DATA_BITS, 8, payload bits per frame; legal range 5..16.
- PARITY_MODE, 0, parity setting: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, number of stop bits required; 1 or 2.
- ERR_CNT_W, 8, width of the error counter.

Ports:
- clk, input, 1, clock; all logic on posedge.
- reset, input, 1, synchronous, active-high; has priority over all other logic.
- in, input, 1, serial line; idle level 1.
- out_data, output, DATA_BITS, received word, LSB first on the line; valid while done=1.
- done, output, 1, one-cycle pulse: frame good.
- parity_err, output, 1, one-cycle pulse: framing correct, parity wrong.
- frame_err, output, 1, one-cycle pulse: a stop bit sampled 0.
- err_count, output, ERR_CNT_W, saturating count of parity_err plus frame_err pulses.

Behaviour:
- Reset values: state IDLE; out_data=0, done=0, parity_err=0, frame_err=0, err_count=0.
- Reset mid-frame discards the partial word and produces no pulse.
- IDLE: in=0 (start bit) goes to DATA with bit index 0; in=1 stays in IDLE.
- DATA: samples in into bit[index] of the shift register and accumulates parity.
  - After DATA_BITS cycles, goes to PAR if PARITY_MODE!=0, else to STOP.
- PAR: samples the parity bit for one cycle, then goes to STOP.
- STOP: samples stop bit k.
  - in=0 goes to ERR.
  - in=1 on the last stop bit goes to RDY; otherwise the next stop bit is sampled.
- RDY (one cycle):
  - done=1 if parity passes or PARITY_MODE=0; else parity_err=1.
  - out_data updates to the captured word only on a good frame.
  - in=0 in this cycle is a back-to-back start bit: go to DATA. in=1 goes to IDLE.
- ERR:
  - frame_err=1 only in the first ERR cycle.
  - Stays in ERR while in=0; in=1 goes to IDLE.
  - A 0 seen on the IDLE transition cycle is not a start bit.
- Parity check: even mode passes when the XOR of data and parity bits is 0; odd mode passes when it is 1.
- Latency: done asserts in the cycle after the last stop bit is sampled. For 8N1, that is 10 cycles after the start-bit cycle.
- out_data holds its last good value between frames. It never shows a partial or bad word.
- err_count increments by 1 on each parity_err or frame_err pulse and saturates at all-ones. The two pulses are never simultaneous.
- Outputs are registered or decoded from the registered state; they have no combinational path from in.

Decomposition:
- Package serial_rx_pkg holds:
  - the state enum (IDLE, DATA, PAR, STOP, RDY, ERR);
  - parity-mode constants PAR_NONE, PAR_EVEN, PAR_ODD;
  - a function parity_ok(mode, acc, pbit).
- One sub-module, serial_rx_shifter, holds:
  - the DATA_BITS shift register, the bit index counter and the parity accumulator;
  - enable and clear inputs driven by the FSM.
- FSM, stop-bit counter and err_count stay in the top level.

Test Plan:
- Default 8N1, reset then line bits 0, A5 sent LSB first (1,0,1,0,0,1,0,1), 1 -> done=1 for one cycle exactly 10 cycles after the start bit; out_data=8'hA5; err_count=0.
- Back-to-back frames 0x3C then 0xFF, with the second start bit placed in the RDY cycle -> two done pulses 10 cycles apart; out_data=3C then FF.
- Stop bit 0, then in held at 0 for 5 cycles, then 1, then a valid frame 0x81 -> frame_err once; no done; err_count=1; then done with out_data=81.
- PARITY_MODE=1, DATA_BITS=7, 0x55 with parity bit 1 (wrong) -> parity_err pulse; out_data unchanged at 0; err_count=1. With parity bit 0 -> done; out_data=7'h55.
- STOP_BITS=2, 0x12 with second stop bit 0 -> frame_err; no done. With stop bits 1,1 -> done 11 cycles after the start bit.
- Reset asserted mid-data; ERR_CNT_W=2 with 5 frame errors -> no pulse after the reset, state returns to IDLE; err_count saturates at 3.

Source files
------------

// File: rtl/serial_rx_pkg.sv
// Shared types and helpers for the serial frame receiver.
package serial_rx_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_DATA = 3'd1,
    S_PAR  = 3'd2,
    S_STOP = 3'd3,
    S_RDY  = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  // acc is the XOR of the payload bits only; pbit is the received parity bit.
  function automatic logic parity_ok(input logic [1:0] mode, input logic acc, input logic pbit);
    case (mode)
      PAR_EVEN: parity_ok = ((acc ^ pbit) == 1'b0);
      PAR_ODD:  parity_ok = ((acc ^ pbit) == 1'b1);
      default:  parity_ok = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/serial_rx_shifter.sv
// Payload capture: LSB-first shift register, bit index and running parity.
module serial_rx_shifter #(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 enable,
  input  logic                 bit_in,
  output logic [DATA_BITS-1:0] word,
  output logic                 acc,
  output logic                 last
);

  localparam int IDX_W = $clog2(DATA_BITS);

  logic [IDX_W-1:0] idx;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      word <= '0;
      idx  <= '0;
      acc  <= 1'b0;
    end else if (enable) begin
      word[idx] <= bit_in;
      acc       <= acc ^ bit_in;
      idx       <= idx + 1'b1;
    end
  end

  assign last = (idx == IDX_W'(DATA_BITS - 1));

endmodule

// File: rtl/serial_frame_rx.sv
// Bit-per-clock serial frame receiver with optional parity, 1/2 stop bits and
// a saturating error counter.
//
// state  | meaning
// IDLE   | line idle, waiting for a 0 start bit
// DATA   | sampling payload bits LSB first
// PAR    | sampling the parity bit
// STOP   | sampling stop bit(s); a 0 is a framing error
// RDY    | frame finished; a 0 here is a back-to-back start bit
// ERR    | framing error, waiting for the line to return to 1
module serial_frame_rx
  import serial_rx_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 done,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  state_t                 state;
  logic                   stop_idx;
  logic                   pbit;
  logic [DATA_BITS-1:0]   word;
  logic                   acc;
  logic                   last;
  logic                   shift_en;
  logic                   shift_clr;
  logic                   stop_last;
  logic                   pok;
  logic [ERR_CNT_W-1:0]   err_next;

  assign shift_en  = (state == S_DATA);
  assign shift_clr = (state == S_IDLE) || (state == S_RDY) || (state == S_ERR);
  assign stop_last = (STOP_BITS == 1) || stop_idx;
  assign pok       = parity_ok(2'(PARITY_MODE), acc, pbit);
  assign err_next  = (err_count == '1) ? err_count : err_count + 1'b1;

  serial_rx_shifter #(.DATA_BITS(DATA_BITS)) u_shifter (
    .clk    (clk),
    .reset  (reset),
    .clear  (shift_clr),
    .enable (shift_en),
    .bit_in (in),
    .word   (word),
    .acc    (acc),
    .last   (last)
  );

  // Pulses are registered on the transition into RDY/ERR so they line up
  // with that state and out_data is already valid alongside done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      stop_idx   <= 1'b0;
      pbit       <= 1'b0;
      out_data   <= '0;
      done       <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      err_count  <= '0;
    end else begin
      done       <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        S_IDLE: if (!in) state <= S_DATA;
        S_DATA: begin
          stop_idx <= 1'b0;
          if (last) state <= (PARITY_MODE != 0) ? S_PAR : S_STOP;
        end
        S_PAR: begin
          pbit  <= in;
          state <= S_STOP;
        end
        S_STOP: begin
          if (!in) begin
            state     <= S_ERR;
            frame_err <= 1'b1;
            err_count <= err_next;
          end else if (stop_last) begin
            state <= S_RDY;
            if (pok) begin
              done     <= 1'b1;
              out_data <= word;
            end else begin
              parity_err <= 1'b1;
              err_count  <= err_next;
            end
          end else begin
            stop_idx <= 1'b1;
          end
        end
        S_RDY:   state <= in ? S_IDLE : S_DATA;
        S_ERR:   if (in) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx: four parameter sets driven by directed and random
// frames, each output compared every cycle against a frame-level model.
module tb_serial_frame_rx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] lin = 4'hF;
  wire  [3:0] dn, pe, fe;
  logic [7:0] od0, od2;
  logic [6:0] od1;
  logic [5:0] od3;
  logic [7:0] ec0, ec1, ec2;
  logic [1:0] ec3;

  int checks = 0;
  int errors = 0;
  int m_od [4];
  int m_ec [4];

  always #5 clk = ~clk;

  serial_frame_rx #(.DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .ERR_CNT_W(8)) u0 (
    .clk(clk), .reset(reset), .in(lin[0]), .out_data(od0), .done(dn[0]),
    .parity_err(pe[0]), .frame_err(fe[0]), .err_count(ec0));
  serial_frame_rx #(.DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(1), .ERR_CNT_W(8)) u1 (
    .clk(clk), .reset(reset), .in(lin[1]), .out_data(od1), .done(dn[1]),
    .parity_err(pe[1]), .frame_err(fe[1]), .err_count(ec1));
  serial_frame_rx #(.DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(2), .ERR_CNT_W(8)) u2 (
    .clk(clk), .reset(reset), .in(lin[2]), .out_data(od2), .done(dn[2]),
    .parity_err(pe[2]), .frame_err(fe[2]), .err_count(ec2));
  serial_frame_rx #(.DATA_BITS(6), .PARITY_MODE(2), .STOP_BITS(1), .ERR_CNT_W(2)) u3 (
    .clk(clk), .reset(reset), .in(lin[3]), .out_data(od3), .done(dn[3]),
    .parity_err(pe[3]), .frame_err(fe[3]), .err_count(ec3));

  function automatic int db(input int k);
    case (k) 0: db = 8; 1: db = 7; 2: db = 8; default: db = 6; endcase
  endfunction
  function automatic int pm(input int k);
    case (k) 1: pm = 1; 3: pm = 2; default: pm = 0; endcase
  endfunction
  function automatic int sb(input int k);
    sb = (k == 2) ? 2 : 1;
  endfunction
  function automatic int cmax(input int k);
    cmax = (k == 3) ? 3 : 255;
  endfunction
  function automatic int get_od(input int k);
    case (k) 0: get_od = int'(od0); 1: get_od = int'(od1); 2: get_od = int'(od2);
      default: get_od = int'(od3); endcase
  endfunction
  function automatic int get_ec(input int k);
    case (k) 0: get_ec = int'(ec0); 1: get_ec = int'(ec1); 2: get_ec = int'(ec2);
      default: get_ec = int'(ec3); endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input int k, input logic edn, input logic epe, input logic efe);
    chk($sformatf("u%0d.done", k), 32'(dn[k]), 32'(edn));
    chk($sformatf("u%0d.parity_err", k), 32'(pe[k]), 32'(epe));
    chk($sformatf("u%0d.frame_err", k), 32'(fe[k]), 32'(efe));
    chk($sformatf("u%0d.out_data", k), get_od(k), m_od[k]);
    chk($sformatf("u%0d.err_count", k), get_ec(k), m_ec[k]);
  endtask

  task automatic step(input int k, input logic b, input logic edn, input logic epe, input logic efe);
    lin[k] = b;
    @(posedge clk); #1;
    check_outs(k, edn, epe, efe);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    lin = 4'hF;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      m_od[k] = 0;
      m_ec[k] = 0;
      check_outs(k, 1'b0, 1'b0, 1'b0);
    end
  endtask

  // One frame on instance k. bad_stop = index of the stop bit sent as 0, or -1.
  task automatic frame(input int k, input int data, input bit bad_par, input int bad_stop, input int hold);
    int n, d, ones;
    logic p;
    n = db(k);
    d = data & ((1 << n) - 1);
    step(k, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) step(k, 1'(d >> i), 1'b0, 1'b0, 1'b0);
    if (pm(k) != 0) begin
      ones = $countones(d);
      p = (pm(k) == 1) ? 1'(ones % 2) : 1'(1 - ones % 2);
      if (bad_par) p = ~p;
      step(k, p, 1'b0, 1'b0, 1'b0);
    end
    for (int s = 0; s < sb(k); s++) begin
      if (s == bad_stop) begin
        if (m_ec[k] < cmax(k)) m_ec[k]++;
        step(k, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int h = 0; h < hold; h++) step(k, 1'b0, 1'b0, 1'b0, 1'b0);
        step(k, 1'b1, 1'b0, 1'b0, 1'b0);
        return;
      end else if (s == sb(k) - 1) begin
        if (bad_par && pm(k) != 0) begin
          if (m_ec[k] < cmax(k)) m_ec[k]++;
          step(k, 1'b1, 1'b0, 1'b1, 1'b0);
        end else begin
          m_od[k] = d;
          step(k, 1'b1, 1'b1, 1'b0, 1'b0);
        end
      end else begin
        step(k, 1'b1, 1'b0, 1'b0, 1'b0);
      end
    end
  endtask

  task automatic idle(input int k, input int cycles);
    for (int i = 0; i < cycles; i++) step(k, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int k, bs;
    bit bp, b2b;
    do_reset();
    idle(0, 2);

    frame(0, 'hA5, 0, -1, 0);
    idle(0, 2);
    frame(0, 'h3C, 0, -1, 0);
    frame(0, 'hFF, 0, -1, 0);
    idle(0, 1);
    frame(0, 'h81, 0, 0, 5);
    frame(0, 'h81, 0, -1, 0);
    idle(0, 1);

    frame(1, 'h55, 1, -1, 0);
    idle(1, 1);
    frame(1, 'h55, 0, -1, 0);
    idle(1, 1);

    frame(2, 'h12, 0, 1, 0);
    idle(2, 1);
    frame(2, 'h12, 0, -1, 0);
    idle(2, 1);

    for (int i = 0; i < 5; i++) frame(3, i * 7, 0, 0, i % 3);
    frame(3, 'h2D, 0, -1, 0);
    idle(3, 1);

    // reset lands in the middle of a payload on u0
    step(0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(0, 1'b0, 1'b0, 1'b0, 1'b0);
    lin[0] = 1'b0;
    do_reset();
    idle(0, 12);
    frame(0, 'h6E, 0, -1, 0);
    idle(0, 1);

    for (int i = 0; i < 30; i++) begin
      k   = int'($urandom_range(0, 3));
      bp  = (pm(k) != 0) && ($urandom_range(0, 3) == 0);
      bs  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, sb(k) - 1)) : -1;
      b2b = ($urandom_range(0, 1) == 1);
      frame(k, int'($urandom), bp, bs, int'($urandom_range(0, 3)));
      if (!b2b || bs >= 0) idle(k, int'($urandom_range(1, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
